// File: rtl/adpll_lock_ctrl.sv
// adpll_lock_ctrl: ADPLL acquisition/lock sequencer (loop reset, coarse/fine gain, lock/loss, retry/fail).
// Optional holdover on loss of lock is enabled by defining ADPLL_LOCK_HOLDOVER_EN.
module adpll_lock_ctrl #(
    parameter int PE_W       = 12,
    parameter int RST_CYC    = 16,
    parameter int FINE_TOL   = 64,
    parameter int FINE_CNT   = 8,
    parameter int LOCK_TOL   = 8,
    parameter int LOCK_CNT   = 32,
    parameter int UNLOCK_TOL = 32,
    parameter int UNLOCK_CNT = 4,
    parameter int TIMEOUT    = 1024,
    parameter int MAX_RETRY  = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic signed [PE_W-1:0] i_pe,
    input  logic                   i_pe_vld,
    output logic                   o_loop_rst,
    output logic                   o_gain_sel,
    output logic                   o_freeze,
    output logic                   o_lock,
    output logic                   o_lost,
    output logic                   o_fail,
    output logic [2:0]             o_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_COARSE = 3'd2,
        S_FINE   = 3'd3,
        S_LOCKED = 3'd4,
        S_HOLD   = 3'd5,
        S_FAIL   = 3'd6
    } state_t;

    localparam int TCW = $clog2(((FINE_CNT > LOCK_CNT) ? FINE_CNT : LOCK_CNT) + 1);
    localparam int OCW = $clog2(UNLOCK_CNT + 1);
    localparam int TOW = $clog2(TIMEOUT + 1);
    localparam int RYW = $clog2(MAX_RETRY + 1);
    localparam int RCW = $clog2(RST_CYC + 1);

    localparam logic [PE_W-1:0] ABS_MAX      = {1'b0, {(PE_W-1){1'b1}}};
    localparam logic [PE_W-1:0] FINE_TOL_V   = PE_W'(FINE_TOL);
    localparam logic [PE_W-1:0] LOCK_TOL_V   = PE_W'(LOCK_TOL);
    localparam logic [PE_W-1:0] UNLOCK_TOL_V = PE_W'(UNLOCK_TOL);
    localparam logic [TCW-1:0]  FINE_CNT_V   = TCW'(FINE_CNT);
    localparam logic [TCW-1:0]  LOCK_CNT_V   = TCW'(LOCK_CNT);
    localparam logic [OCW-1:0]  UNLOCK_CNT_V = OCW'(UNLOCK_CNT);
    localparam logic [TOW-1:0]  TIMEOUT_V    = TOW'(TIMEOUT);
    localparam logic [RYW-1:0]  MAX_RETRY_V  = RYW'(MAX_RETRY);
    localparam logic [RCW-1:0]  RST_LOAD     = RCW'(RST_CYC - 1);

    state_t          state, state_nxt;
    logic [TCW-1:0]  tol_cnt, tol_nxt, tol_inc;
    logic [OCW-1:0]  out_cnt, out_nxt, out_inc;
    logic [TOW-1:0]  to_cnt, to_nxt, to_inc;
    logic [RYW-1:0]  retry_cnt, retry_nxt;
    logic [RCW-1:0]  rst_cnt, rst_nxt;
    logic [PE_W-1:0] abs_err;
    logic            lost_nxt;

`ifdef ADPLL_LOCK_HOLDOVER_EN
    localparam int HOLD_N = 16;
    localparam int HW     = $clog2(HOLD_N + 1);
    localparam logic [HW-1:0]  HOLD_N_V     = HW'(HOLD_N);
    localparam logic [TCW-1:0] RELOCK_CNT_V = TCW'(LOCK_CNT / 4);
    logic [HW-1:0] hold_cnt, hold_nxt, hold_inc;
    assign hold_inc = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
`endif

    // Most-negative sample saturates so it can never alias to a small magnitude.
    always_comb begin
        if (i_pe[PE_W-1] && (i_pe[PE_W-2:0] == '0)) abs_err = ABS_MAX;
        else if (i_pe[PE_W-1])                       abs_err = $unsigned(-i_pe);
        else                                         abs_err = $unsigned(i_pe);
    end

    assign tol_inc = (tol_cnt == '1) ? tol_cnt : tol_cnt + 1'b1;
    assign out_inc = (out_cnt == '1) ? out_cnt : out_cnt + 1'b1;
    assign to_inc  = (to_cnt  == '1) ? to_cnt  : to_cnt  + 1'b1;

    always_comb begin
        state_nxt = state;
        tol_nxt   = tol_cnt;
        out_nxt   = out_cnt;
        to_nxt    = to_cnt;
        retry_nxt = retry_cnt;
        rst_nxt   = rst_cnt;
        lost_nxt  = 1'b0;
`ifdef ADPLL_LOCK_HOLDOVER_EN
        hold_nxt  = hold_cnt;
`endif
        if (!i_en) begin
            state_nxt = S_IDLE;
            tol_nxt   = '0;
            out_nxt   = '0;
            to_nxt    = '0;
            retry_nxt = '0;
            rst_nxt   = '0;
`ifdef ADPLL_LOCK_HOLDOVER_EN
            hold_nxt  = '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_RST;
                    retry_nxt = '0;
                    rst_nxt   = RST_LOAD;
                end
                S_RST: begin
                    tol_nxt = '0;
                    out_nxt = '0;
                    to_nxt  = '0;
                    if (rst_cnt == '0) state_nxt = S_COARSE;
                    else               rst_nxt   = rst_cnt - 1'b1;
                end
                S_COARSE, S_FINE: if (i_pe_vld) begin
                    to_nxt = to_inc;
                    // Timeout takes priority over any promotion on the same sample.
                    if (to_inc == TIMEOUT_V) begin
                        tol_nxt = '0;
                        if (retry_cnt < MAX_RETRY_V) begin
                            retry_nxt = retry_cnt + 1'b1;
                            rst_nxt   = RST_LOAD;
                            state_nxt = S_RST;
                        end else begin
                            state_nxt = S_FAIL;
                        end
                    end else if (state == S_COARSE) begin
                        if (abs_err <= FINE_TOL_V) begin
                            if (tol_inc == FINE_CNT_V) begin
                                state_nxt = S_FINE;
                                tol_nxt   = '0;
                            end else begin
                                tol_nxt = tol_inc;
                            end
                        end else begin
                            tol_nxt = '0;
                        end
                    end else if (abs_err > FINE_TOL_V) begin
                        state_nxt = S_COARSE;
                        tol_nxt   = '0;
                    end else if (abs_err <= LOCK_TOL_V) begin
                        if (tol_inc == LOCK_CNT_V) begin
                            state_nxt = S_LOCKED;
                            tol_nxt   = '0;
                            out_nxt   = '0;
                        end else begin
                            tol_nxt = tol_inc;
                        end
                    end else begin
                        tol_nxt = '0;
                    end
                end
                S_LOCKED: if (i_pe_vld) begin
                    if (abs_err > UNLOCK_TOL_V) begin
                        if (out_inc == UNLOCK_CNT_V) begin
                            lost_nxt = 1'b1;
                            out_nxt  = '0;
                            tol_nxt  = '0;
`ifdef ADPLL_LOCK_HOLDOVER_EN
                            state_nxt = S_HOLD;
                            hold_nxt  = '0;
`else
                            state_nxt = S_COARSE;
                            to_nxt    = '0;
`endif
                        end else begin
                            out_nxt = out_inc;
                        end
                    end else begin
                        out_nxt = '0;
                    end
                end
`ifdef ADPLL_LOCK_HOLDOVER_EN
                S_HOLD: if (i_pe_vld) begin
                    hold_nxt = hold_inc;
                    if ((abs_err <= LOCK_TOL_V) && (tol_inc == RELOCK_CNT_V)) begin
                        state_nxt = S_LOCKED;
                        tol_nxt   = '0;
                        out_nxt   = '0;
                    end else if (hold_inc == HOLD_N_V) begin
                        state_nxt = S_RST;
                        retry_nxt = '0;
                        rst_nxt   = RST_LOAD;
                    end else if (abs_err <= LOCK_TOL_V) begin
                        tol_nxt = tol_inc;
                    end else begin
                        tol_nxt = '0;
                    end
                end
`endif
                S_FAIL: begin
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from next state so they line up with the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            tol_cnt    <= '0;
            out_cnt    <= '0;
            to_cnt     <= '0;
            retry_cnt  <= '0;
            rst_cnt    <= '0;
            o_loop_rst <= 1'b1;
            o_gain_sel <= 1'b0;
            o_lock     <= 1'b0;
            o_lost     <= 1'b0;
            o_fail     <= 1'b0;
        end else begin
            state      <= state_nxt;
            tol_cnt    <= tol_nxt;
            out_cnt    <= out_nxt;
            to_cnt     <= to_nxt;
            retry_cnt  <= retry_nxt;
            rst_cnt    <= rst_nxt;
            o_loop_rst <= (state_nxt == S_IDLE) || (state_nxt == S_RST) || (state_nxt == S_FAIL);
            o_gain_sel <= (state_nxt == S_FINE) || (state_nxt == S_LOCKED) || (state_nxt == S_HOLD);
            o_lock     <= (state_nxt == S_LOCKED);
            o_lost     <= lost_nxt;
            o_fail     <= (state_nxt == S_FAIL);
        end
    end

`ifdef ADPLL_LOCK_HOLDOVER_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_cnt <= '0;
            o_freeze <= 1'b0;
        end else begin
            hold_cnt <= hold_nxt;
            o_freeze <= (state_nxt == S_HOLD);
        end
    end
`else
    assign o_freeze = 1'b0;
`endif

    assign o_state = state;

endmodule
